// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller around the PC register.
// Issues in-order imem requests at pc_cur, buffers responses with their PC in a
// DEPTH-entry in-order queue and hands them to decode via valid/ready.
// A redirect empties the queue; responses still owed to squashed requests are
// counted in drop_cnt_r and discarded as they arrive.
module fetch_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_new,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    // queue storage
    logic [31:0]      pc_q_r   [DEPTH];
    logic [31:0]      inst_q_r [DEPTH];
    logic [DEPTH-1:0] filled_r;

    // pointers and occupancy
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] fill_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;      // allocated entries (filled or not)
    logic [CNT_W-1:0] inflight_r;   // allocated entries still waiting for their response
    logic [CNT_W-1:0] drop_cnt_r;   // responses owed to squashed requests
    logic             run_r;        // low during reset so no request issues while held

    logic [OCC_W-1:0] occ_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             fill_s;
    logic             drop_resp_s;
    logic             id_valid_s;
    logic             pop_s;

    // handshake qualifiers derived from registered state and this cycle's inputs
    always_comb begin
        occ_s       = OCC_W'(count_r) + OCC_W'(drop_cnt_r);
        req_valid_s = run_r & ~redirect_valid & (occ_s < OCC_W'(DEPTH));
        req_fire_s  = req_valid_s & imem_req_ready;
        drop_resp_s = imem_resp_valid & (drop_cnt_r != CNT_W'(0));
        fill_s      = imem_resp_valid & (drop_cnt_r == CNT_W'(0));
        id_valid_s  = filled_r[rd_ptr_r] & ~redirect_valid;
        pop_s       = id_valid_s & id_ready;
    end

    // next PC: redirect beats a fetch advance, otherwise hold
    always_comb begin
        pc_new = pc_cur;
        if (redirect_valid) begin
            pc_new = redirect_pc;
        end else if (req_fire_s) begin
            pc_new = pc_cur + 32'd4;
        end else begin
            pc_new = pc_cur;
        end
    end

    // output port drive; address follows the PC register so it is stable while stalled
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = pc_cur;
        id_valid       = id_valid_s;
        id_inst        = inst_q_r[rd_ptr_r];
        id_pc          = pc_q_r[rd_ptr_r];
    end

    // queue, pointer and drop-counter state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]   <= 32'h0000_0000;
                inst_q_r[i] <= 32'h0000_0000;
            end
            filled_r   <= {DEPTH{1'b0}};
            wr_ptr_r   <= PTR_W'(0);
            fill_ptr_r <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            inflight_r <= CNT_W'(0);
            drop_cnt_r <= CNT_W'(0);
            run_r      <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (redirect_valid) begin
                // every unfilled entry still has a response coming; a response
                // arriving right now settles one of those debts immediately
                filled_r   <= {DEPTH{1'b0}};
                wr_ptr_r   <= PTR_W'(0);
                fill_ptr_r <= PTR_W'(0);
                rd_ptr_r   <= PTR_W'(0);
                count_r    <= CNT_W'(0);
                inflight_r <= CNT_W'(0);
                drop_cnt_r <= drop_cnt_r + inflight_r - CNT_W'(imem_resp_valid);
            end else begin
                if (req_fire_s) begin
                    pc_q_r[wr_ptr_r]   <= pc_cur;
                    filled_r[wr_ptr_r] <= 1'b0;
                    wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
                end
                if (fill_s) begin
                    inst_q_r[fill_ptr_r] <= imem_resp_data;
                    filled_r[fill_ptr_r] <= 1'b1;
                    fill_ptr_r           <= fill_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    filled_r[rd_ptr_r] <= 1'b0;
                    rd_ptr_r           <= rd_ptr_r + PTR_W'(1);
                end
                case ({req_fire_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
                case ({req_fire_s, fill_s})
                    2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                    2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                    default: inflight_r <= inflight_r;
                endcase
                if (drop_resp_s) begin
                    drop_cnt_r <= drop_cnt_r - CNT_W'(1);
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
            end
        end
    end

endmodule
